// File: rtl/spi_prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// spi_prog_loader_pkg
// Shared constants and types for the SPI program loader.
//   WordWidth      : width of a reassembled SPI word / memory data word
//   DefaultEndWord : end-of-program marker used when no override is given
//   ByteEnAll      : byte-enable pattern for full-word writes
//   wr_state_e     : write-port FSM state encoding
// -----------------------------------------------------------------------------
package spi_prog_loader_pkg;

   localparam int unsigned WordWidth = 32;

   localparam logic [WordWidth-1:0] DefaultEndWord = 32'h0000_0FFF;

   localparam logic [3:0] ByteEnAll = 4'hF;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } wr_state_e;

endpackage : spi_prog_loader_pkg

// File: rtl/spi_prog_loader_rx.sv
// -----------------------------------------------------------------------------
// spi_rx_sync
// Receive front end of the SPI program loader: synchronises the three SPI
// lines into clk_i, detects rising SPI clock edges, shifts data MSB first and
// counts bits of the current word.
// Ports:
//   clk_i, rst_ni     : system clock, asynchronous active-low reset
//   spi_i             : serial data from the bridge
//   spi_clk_i         : SPI clock (at most clk_i/4)
//   spi_csb_i         : active-low frame select
//   word_valid        : one-cycle pulse, word_data holds a complete word
//   word_data         : assembled word (valid only with word_valid)
//   frame_err_pulse   : one-cycle pulse, frame ended with a partial word
// -----------------------------------------------------------------------------
module spi_rx_sync
   import spi_prog_loader_pkg::*;
#(
   parameter int unsigned SyncStages = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 spi_i,
   input  logic                 spi_clk_i,
   input  logic                 spi_csb_i,
   output logic                 word_valid,
   output logic [WordWidth-1:0] word_data,
   output logic                 frame_err_pulse
);

   localparam int unsigned CntWidth = $clog2(WordWidth);

   logic [SyncStages-1:0] data_sync;
   logic [SyncStages-1:0] sclk_sync;
   logic [SyncStages-1:0] csb_sync;

   logic data_s, sclk_s, csb_s;
   logic sclk_q, csb_q;
   logic sclk_rise, csb_rise, shift_en;

   logic [WordWidth-1:0] shift_q;
   logic [CntWidth-1:0]  bit_cnt_q;

   // ---- synchroniser stages ----
   // Chip select resets to its idle (deasserted) level so that releasing
   // reset never looks like a frame edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_sync <= '0;
         sclk_sync <= '0;
         csb_sync  <= '1;
      end else begin
         data_sync[0] <= spi_i;
         sclk_sync[0] <= spi_clk_i;
         csb_sync[0]  <= spi_csb_i;
         for (int i = 1; i < int'(SyncStages); i++) begin
            data_sync[i] <= data_sync[i-1];
            sclk_sync[i] <= sclk_sync[i-1];
            csb_sync[i]  <= csb_sync[i-1];
         end
      end
   end

   assign data_s = data_sync[SyncStages-1];
   assign sclk_s = sclk_sync[SyncStages-1];
   assign csb_s  = csb_sync[SyncStages-1];

   // ---- edge detect / shift stage ----
   assign sclk_rise = sclk_s & ~sclk_q;
   assign csb_rise  = csb_s & ~csb_q;
   assign shift_en  = sclk_rise & ~csb_s;

   // The word is reported in the same cycle its last bit is sampled, so the
   // consumer sees the concatenation rather than the registered shifter.
   assign word_data       = {shift_q[WordWidth-2:0], data_s};
   assign word_valid      = shift_en && (bit_cnt_q == CntWidth'(WordWidth - 1));
   assign frame_err_pulse = csb_rise && (bit_cnt_q != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_q    <= 1'b0;
         csb_q     <= 1'b1;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         sclk_q <= sclk_s;
         csb_q  <= csb_s;
         if (shift_en) begin
            shift_q   <= word_data;
            // Counter width is exactly log2(WordWidth): bit 31 wraps to 0.
            bit_cnt_q <= bit_cnt_q + CntWidth'(1);
         end else if (frame_err_pulse) begin
            bit_cnt_q <= '0;
         end
      end
   end

endmodule : spi_rx_sync

// File: rtl/spi_prog_loader.sv
// -----------------------------------------------------------------------------
// spi_prog_loader
// Boot loader that receives 32-bit words over SPI and writes them to
// instruction memory at consecutive word addresses until the end marker
// arrives.
// Ports:
//   clk_i, rst_ni        : system clock, asynchronous active-low reset
//   spi_i/spi_clk_i/
//   spi_csb_i            : SPI data, clock, active-low chip select
//   mem_req_o/mem_we_o   : write request / write enable
//   mem_addr_o           : byte address (AddrWidth bits, wraps)
//   mem_wdata_o/mem_be_o : write data / byte enables
//   mem_gnt_i            : grant; transfer completes when req & gnt
//   done_o               : sticky, end marker received
//   overrun_o            : sticky, a word was dropped (holding reg busy)
//   frame_err_o          : sticky, chip select rose mid-word
//   word_cnt_o           : saturating count of completed writes
// -----------------------------------------------------------------------------
module spi_prog_loader
   import spi_prog_loader_pkg::*;
#(
   parameter int unsigned          AddrWidth  = 14,
   parameter logic [AddrWidth-1:0] BaseAddr   = '0,
   parameter logic [WordWidth-1:0] EndWord    = DefaultEndWord,
   parameter int unsigned          SyncStages = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 spi_i,
   input  logic                 spi_clk_i,
   input  logic                 spi_csb_i,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [WordWidth-1:0] mem_wdata_o,
   output logic [3:0]           mem_be_o,
   input  logic                 mem_gnt_i,
   output logic                 done_o,
   output logic                 overrun_o,
   output logic                 frame_err_o,
   output logic [15:0]          word_cnt_o
);

   logic                 word_valid;
   logic [WordWidth-1:0] word_data;
   logic                 frame_err_pulse;

   wr_state_e            state_q, state_d;
   logic [WordWidth-1:0] hold_q;
   logic [AddrWidth-1:0] addr_q;
   logic [15:0]          cnt_q;
   logic                 done_q, overrun_q, frame_err_q;

   logic grant, is_end, accept, slot_free, load, drop;

   spi_rx_sync #(
      .SyncStages (SyncStages)
   ) u_rx (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .spi_i           (spi_i),
      .spi_clk_i       (spi_clk_i),
      .spi_csb_i       (spi_csb_i),
      .word_valid      (word_valid),
      .word_data       (word_data),
      .frame_err_pulse (frame_err_pulse)
   );

   // ---- word acceptance ----
   // The holding register is occupied exactly while the FSM is in REQ; a
   // grant in the same cycle frees it for an arriving word.
   assign grant     = (state_q == REQ) & mem_gnt_i;
   assign is_end    = word_valid & (word_data == EndWord);
   assign accept    = word_valid & ~done_q & ~is_end;
   assign slot_free = (state_q == IDLE) | grant;
   assign load      = accept & slot_free;
   assign drop      = accept & ~slot_free;

   // ---- write FSM ----
   always_comb begin
      state_d   = state_q;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      mem_be_o  = '0;
      unique case (state_q)
         IDLE: begin
            if (load) state_d = REQ;
         end
         REQ: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            mem_be_o  = ByteEnAll;
            // Back-to-back: a word loaded on the granting cycle keeps REQ.
            if (mem_gnt_i) state_d = load ? REQ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         addr_q      <= BaseAddr;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) hold_q <= word_data;
         if (grant) begin
            addr_q <= addr_q + AddrWidth'(4);
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
         end
         if (is_end)          done_q      <= 1'b1;
         if (drop)            overrun_q   <= 1'b1;
         if (frame_err_pulse) frame_err_q <= 1'b1;
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = hold_q;
   assign word_cnt_o  = cnt_q;
   assign done_o      = done_q;
   assign overrun_o   = overrun_q;
   assign frame_err_o = frame_err_q;

endmodule : spi_prog_loader

// File: tb/tb_spi_prog_loader.sv
module tb_spi_prog_loader;

   localparam logic [31:0] END_W = 32'h0000_0FFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, rst_nb, spi, sclk, csb, gnt, gnt_b;

   logic        req_a, we_a, done_a, ovr_a, ferr_a;
   logic [13:0] addr_a;
   logic [31:0] wdata_a;
   logic [3:0]  be_a;
   logic [15:0] cnt_a;

   logic        req_b, we_b, done_b, ovr_b, ferr_b;
   logic [3:0]  addr_b;
   logic [31:0] wdata_b;
   logic [3:0]  be_b;
   logic [15:0] cnt_b;

   spi_prog_loader #(
      .AddrWidth (14), .BaseAddr (14'h0), .EndWord (END_W), .SyncStages (2)
   ) dut (
      .clk_i (clk), .rst_ni (rst_n), .spi_i (spi), .spi_clk_i (sclk), .spi_csb_i (csb),
      .mem_req_o (req_a), .mem_we_o (we_a), .mem_addr_o (addr_a), .mem_wdata_o (wdata_a),
      .mem_be_o (be_a), .mem_gnt_i (gnt), .done_o (done_a), .overrun_o (ovr_a),
      .frame_err_o (ferr_a), .word_cnt_o (cnt_a)
   );

   spi_prog_loader #(
      .AddrWidth (4), .BaseAddr (4'hC), .EndWord (END_W), .SyncStages (2)
   ) dut_b (
      .clk_i (clk), .rst_ni (rst_nb), .spi_i (spi), .spi_clk_i (sclk), .spi_csb_i (csb),
      .mem_req_o (req_b), .mem_we_o (we_b), .mem_addr_o (addr_b), .mem_wdata_o (wdata_b),
      .mem_be_o (be_b), .mem_gnt_i (gnt_b), .done_o (done_b), .overrun_o (ovr_b),
      .frame_err_o (ferr_b), .word_cnt_o (cnt_b)
   );

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_a[$];
   wr_t exp_b[$];
   wr_t e_a, e_b;

   bit          chk_stable = 1'b0;
   logic [31:0] stable_data = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard for the default instance: every completed handshake must
   // match the oldest expected write.
   always @(negedge clk) begin
      if (req_a === 1'b1 && gnt === 1'b1) begin
         if (exp_a.size() == 0) begin
            check("a_unexpected_write_data", wdata_a, 32'hxxxx_xxxx);
         end else begin
            e_a = exp_a.pop_front();
            check("a_wr_addr", 32'(addr_a), e_a.addr);
            check("a_wr_data", wdata_a, e_a.data);
            check("a_wr_we",   32'(we_a), 32'd1);
            check("a_wr_be",   32'(be_a), 32'hF);
         end
      end
      if (chk_stable) begin
         check("a_hold_req",  32'(req_a), 32'd1);
         check("a_hold_addr", 32'(addr_a), 32'd0);
         check("a_hold_data", wdata_a, stable_data);
         check("a_hold_be",   32'(be_a), 32'hF);
      end
   end

   always @(negedge clk) begin
      if (req_b === 1'b1 && gnt_b === 1'b1) begin
         if (exp_b.size() == 0) begin
            check("b_unexpected_write_data", wdata_b, 32'hxxxx_xxxx);
         end else begin
            e_b = exp_b.pop_front();
            check("b_wr_addr", 32'(addr_b), e_b.addr);
            check("b_wr_data", wdata_b, e_b.data);
            check("b_wr_be",   32'(be_b), 32'hF);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic spi_bit(input logic b);
      spi = b;
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      csb = 1'b0;
      tick(4);
      for (int i = 31; i >= 0; i--) spi_bit(w[i]);
      tick(4);
      csb = 1'b1;
      tick(8);
   endtask

   task automatic push_a(input logic [31:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      exp_a.push_back(w);
   endtask

   task automatic push_b(input logic [31:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      exp_b.push_back(w);
   endtask

   task automatic chk_reset_a(input string tag);
      check({tag, "_req"},   32'(req_a), 32'd0);
      check({tag, "_we"},    32'(we_a), 32'd0);
      check({tag, "_addr"},  32'(addr_a), 32'd0);
      check({tag, "_wdata"}, wdata_a, 32'd0);
      check({tag, "_be"},    32'(be_a), 32'd0);
      check({tag, "_done"},  32'(done_a), 32'd0);
      check({tag, "_ovr"},   32'(ovr_a), 32'd0);
      check({tag, "_ferr"},  32'(ferr_a), 32'd0);
      check({tag, "_cnt"},   32'(cnt_a), 32'd0);
   endtask

   task automatic reset_a();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   logic [31:0] w4;

   initial begin
      rst_n = 1'b0; rst_nb = 1'b0;
      spi = 1'b0; sclk = 1'b0; csb = 1'b1;
      gnt = 1'b0; gnt_b = 1'b0;
      tick(3);
      chk_reset_a("rst_held");
      check("b_rst_addr", 32'(addr_b), 32'hC);
      rst_n = 1'b1;
      tick(2);

      // Three words and the end marker with grant tied high; a word after
      // the marker must be ignored.
      gnt = 1'b1;
      push_a(32'h0, 32'hDEADBEEF);
      push_a(32'h4, 32'h00000013);
      push_a(32'h8, 32'h12345678);
      send_word(32'hDEADBEEF);
      send_word(32'h00000013);
      send_word(32'h12345678);
      send_word(END_W);
      tick(6);
      check("t1_cnt",  32'(cnt_a), 32'd3);
      check("t1_done", 32'(done_a), 32'd1);
      check("t1_ovr",  32'(ovr_a), 32'd0);
      check("t1_addr", 32'(addr_a), 32'hC);
      send_word(32'hCAFE0001);
      tick(6);
      check("t1_post_done_cnt", 32'(cnt_a), 32'd3);
      check("t1_post_done_ovr", 32'(ovr_a), 32'd0);
      check("t1_post_done_req", 32'(req_a), 32'd0);
      check("t1_queue", 32'(exp_a.size()), 32'd0);

      // Grant withheld: request holds stable, second word overruns.
      gnt = 1'b0;
      reset_a();
      send_word(32'h1111_1111);
      check("t2_req",  32'(req_a), 32'd1);
      check("t2_data", wdata_a, 32'h1111_1111);
      stable_data = 32'h1111_1111;
      chk_stable  = 1'b1;
      send_word(32'h2222_2222);
      tick(10);
      chk_stable  = 1'b0;
      check("t2_ovr",     32'(ovr_a), 32'd1);
      check("t2_cnt_pre", 32'(cnt_a), 32'd0);
      push_a(32'h0, 32'h1111_1111);
      gnt = 1'b1;
      tick(4);
      gnt = 1'b0;
      check("t2_cnt",   32'(cnt_a), 32'd1);
      check("t2_req_lo", 32'(req_a), 32'd0);
      check("t2_queue", 32'(exp_a.size()), 32'd0);

      // Grant lands exactly on the cycle the second word completes.
      reset_a();
      push_a(32'h0, 32'h3333_3333);
      push_a(32'h4, 32'h4444_4444);
      send_word(32'h3333_3333);
      check("t3_req1", 32'(req_a), 32'd1);
      w4  = 32'h4444_4444;
      csb = 1'b0;
      tick(4);
      for (int i = 31; i >= 1; i--) spi_bit(w4[i]);
      spi = w4[0];
      tick(4);
      sclk = 1'b1;
      tick(2);
      gnt = 1'b1;
      tick(1);
      gnt = 1'b0;
      tick(1);
      sclk = 1'b0;
      tick(4);
      csb = 1'b1;
      tick(4);
      check("t3_ovr",   32'(ovr_a), 32'd0);
      check("t3_req2",  32'(req_a), 32'd1);
      check("t3_addr2", 32'(addr_a), 32'h4);
      check("t3_data2", wdata_a, 32'h4444_4444);
      gnt = 1'b1;
      tick(3);
      gnt = 1'b0;
      check("t3_cnt",   32'(cnt_a), 32'd2);
      check("t3_queue", 32'(exp_a.size()), 32'd0);

      // Frame broken after 17 bits, then a full word.
      reset_a();
      gnt = 1'b1;
      csb = 1'b0;
      tick(4);
      for (int i = 0; i < 17; i++) spi_bit(i[0]);
      tick(4);
      csb = 1'b1;
      tick(8);
      check("t4_ferr",    32'(ferr_a), 32'd1);
      check("t4_cnt_pre", 32'(cnt_a), 32'd0);
      push_a(32'h0, 32'hA5A5A5A5);
      send_word(32'hA5A5A5A5);
      tick(4);
      check("t4_cnt",   32'(cnt_a), 32'd1);
      check("t4_ovr",   32'(ovr_a), 32'd0);
      check("t4_queue", 32'(exp_a.size()), 32'd0);

      // Reset mid-word.
      reset_a();
      csb = 1'b0;
      tick(4);
      for (int i = 0; i < 10; i++) spi_bit(1'b1);
      rst_n = 1'b0;
      csb   = 1'b1;
      sclk  = 1'b0;
      #1;
      chk_reset_a("rst_mid_word");
      tick(2);
      rst_n = 1'b1;
      tick(4);
      push_a(32'h0, 32'h5555_5555);
      send_word(32'h5555_5555);
      tick(4);
      check("t6a_cnt",  32'(cnt_a), 32'd1);
      check("t6a_ferr", 32'(ferr_a), 32'd0);

      // Reset while a request is pending: no write of that word.
      gnt = 1'b0;
      send_word(32'h6666_6666);
      check("t6b_req", 32'(req_a), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_a("rst_mid_req");
      tick(2);
      rst_n = 1'b1;
      tick(2);
      gnt = 1'b1;
      push_a(32'h0, 32'h7777_7777);
      send_word(32'h7777_7777);
      tick(4);
      check("t6b_cnt",   32'(cnt_a), 32'd1);
      check("t6b_queue", 32'(exp_a.size()), 32'd0);

      // Address wrap on the narrow instance.
      rst_n  = 1'b0;
      gnt    = 1'b0;
      rst_nb = 1'b1;
      gnt_b  = 1'b1;
      tick(4);
      push_b(32'hC, 32'h0BAD_F00D);
      push_b(32'h0, 32'h1357_9BDF);
      send_word(32'h0BAD_F00D);
      send_word(32'h1357_9BDF);
      tick(4);
      check("t5_cnt",   32'(cnt_b), 32'd2);
      check("t5_addr",  32'(addr_b), 32'h4);
      check("t5_ovr",   32'(ovr_b), 32'd0);
      check("t5_queue", 32'(exp_b.size()), 32'd0);

      tick(10);
      check("final_queue_a", 32'(exp_a.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_spi_prog_loader

// File: doc/spi_prog_loader.md
Name: spi_prog_loader

Overview:
- SoC-side SPI receiver that consumes the serial stream from the UART-to-SPI bridge (data, clock, active-low chip select).
- Reassembles 32-bit words, MSB first, and writes them into instruction memory through a req/gnt port at auto-incrementing word addresses.
- Signals boot-load completion when it receives a configurable end-of-program marker.

Parameters:
- AddrWidth, 14, memory byte-address width.
- BaseAddr, 0, byte address of the first word written; must be 4-byte aligned.
- EndWord, 32'h0000_0FFF, marker word that terminates loading; never written to memory.
- SyncStages, 2, flip-flop stages on each SPI input.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- spi_i  input  1  serial data, sampled on rising spi_clk_i
- spi_clk_i  input  1  SPI clock; must be at most clk_i/4
- spi_csb_i  input  1  active-low frame select
- mem_req_o  output  1  write request
- mem_we_o  output  1  write enable; high whenever mem_req_o is high
- mem_addr_o  output  AddrWidth  byte address
- mem_wdata_o  output  32  write data
- mem_be_o  output  4  byte enables; always 4'hF during a request
- mem_gnt_i  input  1  grant; the transfer completes in the cycle req and gnt are both high
- done_o  output  1  sticky; EndWord received
- overrun_o  output  1  sticky; a word was dropped because the holding register was busy
- frame_err_o  output  1  sticky; chip select deasserted mid-word
- word_cnt_o  output  16  count of words written, saturating

Behaviour:
- Reset values: every output is 0, mem_addr_o = BaseAddr, and all FSMs are in IDLE.
- Synchronisation: spi_i, spi_clk_i and spi_csb_i each pass through SyncStages flip-flops.
- Bit sampling: a rising edge is detected as the synced clock going from 0 to 1. The synced data bit is shifted in on that edge only while synced csb is 0.
- Bit counter: counts 0..31. On bit 31 the full word is complete in the same cycle; the counter returns to 0.
- csb rising with the counter not at 0: discard the partial word, clear the counter, set frame_err_o. csb rising with the counter at 0 has no effect.
- Completed word handling:
  - Word equals EndWord: set done_o; nothing is written.
  - Word does not equal EndWord and the holding register is empty: load it into the holding register.
  - Word does not equal EndWord and the holding register is occupied: drop the word and set overrun_o.
- Write FSM:
  - IDLE: when the holding register becomes valid, go to REQ. mem_req_o rises the cycle after the word completes (latency 1).
  - REQ: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o stay stable until mem_gnt_i = 1.
  - On grant: clear the holding register, add 4 to mem_addr_o (wraps modulo 2^AddrWidth), increment word_cnt_o (saturates at 16'hFFFF), return to IDLE.
  - A grant in the same cycle a new word completes frees the slot. The new word is accepted with no overrun and is requested in the next cycle.
- After done_o:
  - A pending holding-register write still completes.
  - Further SPI words are ignored: no write, no overrun.
  - done_o stays high until reset.
- A Gnt arriving without req is ignored.
- Reset asserted mid-word or mid-request: everything returns to its reset state immediately, with no partial write.

Decomposition:
- Package spi_prog_loader_pkg holds:
  - WordWidth = 32
  - the write-FSM state typedef (IDLE, REQ)
  - the default EndWord constant
- One sub-module, spi_rx_sync: input synchronisers, rising-edge detect, shift register and bit counter. It outputs word_valid (a 1-cycle pulse), word_data and frame_err_pulse.
- The top level holds the holding register, write FSM, address and counters, and sticky flags.

Test Plan:
- Send 3 words (32'hDEADBEEF, 32'h00000013, 32'h12345678), then EndWord, with mem_gnt_i tied high -> writes at byte addresses 0x0, 0x4 and 0x8 with that data; be = 4'hF; word_cnt_o = 3; done_o = 1; no write of EndWord.
- mem_gnt_i held low for 200 cycles on the first word while a second word arrives -> the first request holds stable, the second word is dropped, overrun_o = 1, word_cnt_o = 1 after grant.
- Grant delayed until exactly the cycle the second word completes -> no overrun; the second word is written at 0x4 in the following request.
- csb deasserted after 17 bits, then a full word 32'hA5A5A5A5 is sent -> frame_err_o = 1, a single write of 32'hA5A5A5A5 at BaseAddr.
- With AddrWidth = 4 and BaseAddr = 0xC, send 2 words -> addresses 0xC, then 0x0 (wrap).
- rst_ni pulsed low mid-word and again during REQ -> outputs return to reset values; a subsequent full word is written at BaseAddr.
